rgmii_rx_speed_adapt: RTL and testbench
=======================================

# rgmii_rx_speed_adapt

Tri-speed RGMII receive adapter for the ETH_UDP path. It sits directly after the DDR input capture (rising/falling-edge samples of `rgmii_rx_ctl`/`rgmii_rxd`) and before the GMII MAC receive logic. It produces a byte-wide GMII stream with a byte strobe in 1000/100/10 Mb/s modes. It also decodes and filters RGMII in-band link status and selects the operating speed automatically or by override.

## Interface
Parameters:
- `AUTO_SPEED`, 1, 1 = operating speed taken from filtered in-band status; 0 = from `speed_mode`
- `INBAND_FILTER`, 4, consecutive identical in-band samples required before status updates (2..15)
- `CNT_W`, 16, width of the saturating alignment-error counter

Ports:
- `gmii_rx_clk`  in  1  receive clock (RGMII rxc after capture); sole clock
- `reset`  in  1  asynchronous, active-high reset
- `speed_mode`  in  2  override speed: 00 10M, 01 100M, 10 1000M, 11 treated as 1000M
- `ddr_ctl_r`, `ddr_ctl_f`  in  1 each  rx_ctl sampled on rising / falling edge
- `ddr_d_r`, `ddr_d_f`  in  4 each  rxd sampled on rising / falling edge
- `gmii_rx_en`  out  1  byte strobe; `gmii_rxd`/`gmii_rx_dv`/`gmii_rx_er` are valid only when high
- `gmii_rx_dv`  out  1  data valid
- `gmii_rx_er`  out  1  receive error
- `gmii_rxd`  out  8  received byte
- `link_up`  out  1  filtered in-band link status
- `link_speed`  out  2  filtered in-band speed
- `full_duplex`  out  1  filtered in-band duplex
- `speed_used`  out  2  speed currently applied by the datapath
- `align_err_cnt`  out  CNT_W  saturating count of odd-nibble frames

## Operation
- 1000M: every cycle is registered as follows.
  - `gmii_rxd={ddr_d_f,ddr_d_r}`, `gmii_rx_dv=ddr_ctl_r`, `gmii_rx_er=ddr_ctl_r^ddr_ctl_f`.
  - `gmii_rx_en=1`.
- 10/100M: one nibble per cycle from `ddr_d_r`; `dv=ddr_ctl_r`, `err=ddr_ctl_r^ddr_ctl_f`. Nibble FSM:
  - IDLE: dv=0, or dv=1 with a nibble other than 5/D (ignored). Nibble 5 stores the low nibble → PRE_HI.
  - PRE_HI: nibble D emits 0xD5 → DATA_LO. Nibble 5 emits 0x55 → PRE_LO. Any other nibble emits {n,5} with er=1 → DATA_LO.
  - PRE_LO: nibble 5 → PRE_HI. Nibble D is treated as the high nibble of an SFD whose low nibble was lost: emit 0xD5 → DATA_LO.
  - DATA_LO: store the low nibble → DATA_HI.
  - DATA_HI: emit {n,low}; er = OR of both nibbles' err → DATA_LO.
  - dv falling in PRE_HI or DATA_HI (odd nibble count): emit {4'h0,low} with er=1, increment `align_err_cnt` (saturating) → IDLE.
  - dv falling in any other state: → IDLE with no emit.
- Emitted bytes carry `gmii_rx_dv=1`. Between bytes, `gmii_rx_en=0`, and `gmii_rxd`/`gmii_rx_dv`/`gmii_rx_er` hold their last values.
- In-band status is sampled on cycles with `ddr_ctl_r=0 && ddr_ctl_f=0`, decoding `ddr_d_r` as:
  - [0] link
  - [2:1] speed
  - [3] duplex
- In-band outputs update only after INBAND_FILTER consecutive identical samples. Any differing sample restarts the count. Cycles with ctl≠00 neither count nor reset the filter.
- Speed-change rule: `speed_used` takes the new speed (`AUTO_SPEED ? link_speed : speed_mode`) only while the FSM is in IDLE and the current `ddr_ctl_r=0`. A change requested mid-frame is deferred to frame end.
- On a speed change the FSM is forced to IDLE and any held nibble is dropped.

## Timing
- Reset values:
  - `gmii_rx_en`, `gmii_rx_dv`, `gmii_rx_er`, `gmii_rxd`: 0
  - `link_up`, `full_duplex`: 0
  - `link_speed`, `speed_used`: 2'b10
  - `align_err_cnt`: 0
  - FSM: IDLE; filter count: 0
- Latency:
  - 1000M: 1 cycle from input to output.
  - 10/100M: byte and strobe appear 1 cycle after the high-nibble sample.
  - Odd-nibble flush: 1 cycle after the dv=0 sample.
- In-band status: outputs change exactly INBAND_FILTER cycles after the first sample of a new stable value.
- `speed_used` changes the cycle after the change condition holds. The datapath uses the new mode from the next cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately; no partial byte is emitted after release.
- Counter saturates at 2^CNT_W−1.

## Structure
- Shared package `eth_rgmii_pkg`:
  - speed encodings `SPD_10`/`SPD_100`/`SPD_1000`
  - nibble constants `PRE_NIB=4'h5`, `SFD_NIB=4'hD`
  - FSM state enum
- Sub-module `rgmii_inband_status`: the in-band sample filter, producing `link_up`/`link_speed`/`full_duplex`.

## Test plan
- 1000M, 7×0x55 + 0xD5 + 64 payload bytes → identical byte stream 1 cycle later, en=1 every cycle, er=0.
- 100M, nibbles 5×15, D, then payload 0x12,0x34 as nibbles 2,1,4,3 → bytes 0x55×7, 0xD5, 0x12, 0x34 with en every second cycle.
- 100M frame ending after an odd nibble 0xA → final byte 0x0A with er=1, align_err_cnt=1.
- AUTO_SPEED=1, in-band 4'b0011 (link, 100M) held 4 cycles → link_up=1 and link_speed=01 on cycle 4. Held only 3 cycles then changed → no update.
- In-band speed change to 10M during an active frame → speed_used stays 10 (1000M) until dv falls, then becomes 00 the next cycle.
- 10M frame with ctl_f≠ctl_r on one data nibble → that byte has er=1; reset pulse mid-frame → all outputs 0, FSM restarts cleanly on the next frame.

Source files
------------

// File: rtl/eth_rgmii_pkg.sv
// eth_rgmii_pkg: shared speed encodings, RGMII nibble constants and receive FSM states
package eth_rgmii_pkg;
  localparam logic [1:0] SPD_10 = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;
  typedef enum logic [2:0] {IDLE, PRE_HI, PRE_LO, DATA_LO, DATA_HI} nib_state_e;
  // 2'b11 is not a real speed and is run as gigabit
  function automatic logic [1:0] norm_spd(input logic [1:0] s);
    return (s == 2'b11) ? SPD_1000 : s;
  endfunction
endpackage

// File: rtl/rgmii_rx_speed_adapt_if.sv
// rgmii_rx_speed_adapt_if: DDR capture samples in, GMII byte stream and link status out
interface rgmii_rx_speed_adapt_if #(parameter int CNT_W = 16);
  logic [1:0] speed_mode;
  logic ddr_ctl_r, ddr_ctl_f;
  logic [3:0] ddr_d_r, ddr_d_f;
  logic gmii_rx_en, gmii_rx_dv, gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic link_up, full_duplex;
  logic [1:0] link_speed, speed_used;
  logic [CNT_W-1:0] align_err_cnt;
  modport master(
    output speed_mode, ddr_ctl_r, ddr_ctl_f, ddr_d_r, ddr_d_f,
    input gmii_rx_en, gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up, full_duplex, link_speed,
    speed_used, align_err_cnt
  );
  modport slave(
    input speed_mode, ddr_ctl_r, ddr_ctl_f, ddr_d_r, ddr_d_f,
    output gmii_rx_en, gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up, full_duplex, link_speed,
    speed_used, align_err_cnt
  );
endinterface

// File: rtl/rgmii_inband_status.sv
// rgmii_inband_status: debounces RGMII in-band link/speed/duplex sampled during inter-frame gaps
module rgmii_inband_status #(
  parameter int INBAND_FILTER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctl_r_i,
  input  logic       ctl_f_i,
  input  logic [3:0] d_r_i,
  output logic       link_up_o,
  output logic [1:0] link_speed_o,
  output logic       full_duplex_o
);
  localparam logic [3:0] FILT = 4'(INBAND_FILTER);
  logic samp;
  logic [3:0] cand_q, cand_d, cnt_q, cnt_d, stat_q, stat_d;
  always_comb begin
    samp = !ctl_r_i && !ctl_f_i;
    cand_d = samp ? d_r_i : cand_q;
    cnt_d = !samp ? cnt_q : (d_r_i != cand_q) ? 4'd1 : (cnt_q == FILT) ? cnt_q : cnt_q + 4'd1;
    stat_d = (samp && cnt_d == FILT) ? d_r_i : stat_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand_q <= '0;
      cnt_q <= '0;
      stat_q <= 4'b0100;
    end else begin
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      stat_q <= stat_d;
    end
  assign link_up_o = stat_q[0];
  assign link_speed_o = stat_q[2:1];
  assign full_duplex_o = stat_q[3];
endmodule

// File: rtl/rgmii_rx_speed_adapt.sv
// rgmii_rx_speed_adapt: tri-speed RGMII receive adapter producing a strobed GMII byte stream
module rgmii_rx_speed_adapt #(
  parameter bit AUTO_SPEED = 1'b1,
  parameter int INBAND_FILTER = 4,
  parameter int CNT_W = 16
) (
  input logic gmii_rx_clk,
  input logic reset,
  rgmii_rx_speed_adapt_if.slave bus
);
  import eth_rgmii_pkg::*;
  nib_state_e st_q, st_d;
  logic [3:0] n, lo_q, lo_d;
  logic dv, er, gig, chg, emit, ee, flush, lo_er_q, lo_er_d;
  logic en_q, en_d, dvo_q, dvo_d, ero_q, ero_d;
  logic [7:0] eb, rxd_q, rxd_d;
  logic [1:0] spd_q, spd_d, tgt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rgmii_inband_status #(.INBAND_FILTER(INBAND_FILTER)) u_inband (
    .clk(gmii_rx_clk), .rst(reset), .ctl_r_i(bus.ddr_ctl_r), .ctl_f_i(bus.ddr_ctl_f),
    .d_r_i(bus.ddr_d_r), .link_up_o(bus.link_up), .link_speed_o(bus.link_speed),
    .full_duplex_o(bus.full_duplex)
  );
  always_comb begin
    dv = bus.ddr_ctl_r;
    er = bus.ddr_ctl_r ^ bus.ddr_ctl_f;
    n = bus.ddr_d_r;
    gig = spd_q[1];
    st_d = st_q;
    lo_d = lo_q;
    lo_er_d = lo_er_q;
    emit = 1'b0;
    eb = {n, lo_q};
    ee = lo_er_q | er;
    flush = 1'b0;
    if (!dv) begin
      st_d = IDLE;
      flush = (st_q == PRE_HI) || (st_q == DATA_HI);
      emit = flush;
      eb = {4'h0, lo_q};
      ee = 1'b1;
    end else begin
      case (st_q)
        IDLE: begin
          lo_d = n;
          lo_er_d = er;
          st_d = (n == PRE_NIB) ? PRE_HI : IDLE;
        end
        PRE_HI: begin
          emit = 1'b1;
          ee = (n == PRE_NIB || n == SFD_NIB) ? lo_er_q | er : 1'b1;
          st_d = (n == PRE_NIB) ? PRE_LO : DATA_LO;
        end
        // an SFD here means the preamble lost a nibble; realign on it
        PRE_LO: begin
          lo_d = n;
          lo_er_d = er;
          emit = (n == SFD_NIB);
          eb = {SFD_NIB, PRE_NIB};
          ee = er;
          st_d = (n == PRE_NIB) ? PRE_HI : (n == SFD_NIB) ? DATA_LO : IDLE;
        end
        DATA_LO: begin
          lo_d = n;
          lo_er_d = er;
          st_d = DATA_HI;
        end
        DATA_HI: begin
          emit = 1'b1;
          st_d = DATA_LO;
        end
        default: st_d = IDLE;
      endcase
    end
    if (gig) st_d = IDLE;
    tgt = norm_spd(AUTO_SPEED ? bus.link_speed : bus.speed_mode);
    chg = (st_q == IDLE) && !dv && (tgt != spd_q);
    spd_d = chg ? tgt : spd_q;
    en_d = gig | emit;
    rxd_d = gig ? {bus.ddr_d_f, n} : emit ? eb : rxd_q;
    dvo_d = gig ? dv : emit ? 1'b1 : dvo_q;
    ero_d = gig ? er : emit ? ee : ero_q;
    cnt_d = (!gig && flush && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge gmii_rx_clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      lo_q <= '0;
      lo_er_q <= 1'b0;
      spd_q <= SPD_1000;
      cnt_q <= '0;
      en_q <= 1'b0;
      dvo_q <= 1'b0;
      ero_q <= 1'b0;
      rxd_q <= '0;
    end else begin
      st_q <= st_d;
      lo_q <= lo_d;
      lo_er_q <= lo_er_d;
      spd_q <= spd_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      dvo_q <= dvo_d;
      ero_q <= ero_d;
      rxd_q <= rxd_d;
    end
  assign bus.gmii_rx_en = en_q;
  assign bus.gmii_rx_dv = dvo_q;
  assign bus.gmii_rx_er = ero_q;
  assign bus.gmii_rxd = rxd_q;
  assign bus.speed_used = spd_q;
  assign bus.align_err_cnt = cnt_q;
endmodule

// File: tb/tb_rgmii_rx_speed_adapt.sv
// tb_rgmii_rx_speed_adapt: table-driven gigabit vectors plus scoreboarded 10/100 and corner sequences
module tb_rgmii_rx_speed_adapt;
  typedef struct {
    logic cr, cf;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic exp_dv, exp_er;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  logic sb_on = 1'b0;
  logic sbd;
  logic [9:0] sbq[$];
  logic [9:0] ex;
  vec_t tbl[76];
  rgmii_rx_speed_adapt_if #(.CNT_W(16)) bus();
  rgmii_rx_speed_adapt #(.AUTO_SPEED(1'b1), .INBAND_FILTER(4), .CNT_W(16)) dut (
    .gmii_rx_clk(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic cyc(input logic cr, input logic cf, input logic [3:0] dr, input logic [3:0] df);
    bus.ddr_ctl_r = cr;
    bus.ddr_ctl_f = cf;
    bus.ddr_d_r = dr;
    bus.ddr_d_f = df;
    @(posedge clk);
    #1;
  endtask
  task automatic cyc_g(input logic cr, input logic cf, input logic [3:0] dr, input logic [3:0] df);
    sbq.push_back({df, dr, cr, cr ^ cf});
    cyc(cr, cf, dr, df);
  endtask
  task automatic push(input logic [7:0] b, input logic e);
    sbq.push_back({b, 1'b1, e});
  endtask
  task automatic nibs(input logic [3:0] ns[$]);
    foreach (ns[k]) cyc(1'b1, 1'b1, ns[k], 4'h0);
  endtask
  initial begin
    for (int i = 0; i < 72; i++) begin
      tbl[i].cr = 1'b1;
      tbl[i].cf = 1'b1;
      tbl[i].d = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'(i * 29 + 3);
      tbl[i].exp_d = tbl[i].d;
      tbl[i].exp_dv = 1'b1;
      tbl[i].exp_er = 1'b0;
    end
    tbl[72] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b1};
    tbl[73] = '{1'b0, 1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1};
    tbl[74] = '{1'b0, 1'b0, 8'h0D, 8'h0D, 1'b0, 1'b0};
    tbl[75] = '{1'b0, 1'b0, 8'h0D, 8'h0D, 1'b0, 1'b0};
    fork
      forever begin
        @(posedge clk);
        sbd = sb_on;
        @(negedge clk);
        if (!rst && sbd && bus.gmii_rx_en) begin
          nvec++;
          if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL sb_extra: got rxd=%h dv=%b er=%b, expected no strobe",
                     bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er);
          end else begin
            ex = sbq.pop_front();
            if ({bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er} !== ex) begin
              nerr++;
              $display("FAIL sb_byte: got rxd=%h dv=%b er=%b, expected rxd=%h dv=%b er=%b",
                       bus.gmii_rxd, bus.gmii_rx_dv, bus.gmii_rx_er, ex[9:2], ex[1], ex[0]);
            end
          end
        end
      end
    join_none
    bus.speed_mode = 2'b10;
    bus.ddr_ctl_r = 1'b0;
    bus.ddr_ctl_f = 1'b0;
    bus.ddr_d_r = 4'h0;
    bus.ddr_d_f = 4'h0;
    @(posedge clk);
    #1;
    chk("rst_en", bus.gmii_rx_en, 0);
    chk("rst_dv", bus.gmii_rx_dv, 0);
    chk("rst_er", bus.gmii_rx_er, 0);
    chk("rst_rxd", bus.gmii_rxd, 0);
    chk("rst_link", bus.link_up, 0);
    chk("rst_dup", bus.full_duplex, 0);
    chk("rst_lspd", bus.link_speed, 2'b10);
    chk("rst_spd", bus.speed_used, 2'b10);
    chk("rst_cnt", bus.align_err_cnt, 0);
    rst = 1'b0;
    repeat (6) cyc(1'b0, 1'b0, 4'hD, 4'h0);
    chk("ib_link", bus.link_up, 1);
    chk("ib_dup", bus.full_duplex, 1);
    chk("ib_spd_gig", bus.speed_used, 2'b10);
    // gigabit table
    sb_on = 1'b1;
    foreach (tbl[i]) begin
      sbq.push_back({tbl[i].exp_d, tbl[i].exp_dv, tbl[i].exp_er});
      cyc(tbl[i].cr, tbl[i].cf, tbl[i].d[3:0], tbl[i].d[7:4]);
    end
    sb_on = 1'b0;
    cyc(1'b0, 1'b0, 4'hD, 4'h0);
    chk("gig_drain", sbq.size(), 0);
    // in-band filter: 3 samples then a glitch must not update
    repeat (3) cyc(1'b0, 1'b0, 4'hB, 4'h0);
    chk("ib3_lspd", bus.link_speed, 2'b10);
    cyc(1'b0, 1'b0, 4'hD, 4'h0);
    repeat (3) cyc(1'b0, 1'b0, 4'hB, 4'h0);
    chk("ib_cyc3_lspd", bus.link_speed, 2'b10);
    cyc(1'b0, 1'b0, 4'hB, 4'h0);
    chk("ib_cyc4_lspd", bus.link_speed, 2'b01);
    chk("ib_cyc4_spd", bus.speed_used, 2'b10);
    cyc(1'b0, 1'b0, 4'hB, 4'h0);
    chk("spd_100", bus.speed_used, 2'b01);
    repeat (2) cyc(1'b0, 1'b0, 4'hB, 4'h0);
    // 100M frame with trailing odd nibble
    sb_on = 1'b1;
    repeat (7) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    push(8'h12, 1'b0);
    push(8'h34, 1'b0);
    push(8'h0A, 1'b1);
    repeat (15) cyc(1'b1, 1'b1, 4'h5, 4'h0);
    nibs('{4'hD, 4'h2, 4'h1, 4'h4, 4'h3, 4'hA});
    repeat (2) cyc(1'b0, 1'b0, 4'hB, 4'h0);
    chk("m100_drain", sbq.size(), 0);
    chk("m100_cnt", bus.align_err_cnt, 1);
    // back to gigabit
    sb_on = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 4'hD, 4'h0);
    chk("spd_back_gig", bus.speed_used, 2'b10);
    repeat (2) cyc(1'b0, 1'b0, 4'hD, 4'h0);
    // speed change requested just before a gigabit frame is deferred to its end
    sb_on = 1'b1;
    repeat (4) cyc_g(1'b0, 1'b0, 4'h9, 4'h0);
    chk("def_lspd", bus.link_speed, 2'b00);
    chk("def_spd0", bus.speed_used, 2'b10);
    repeat (3) cyc_g(1'b1, 1'b1, 4'h5, 4'h5);
    chk("def_spd_mid", bus.speed_used, 2'b10);
    cyc_g(1'b1, 1'b1, 4'h5, 4'hD);
    cyc_g(1'b1, 1'b1, 4'h1, 4'h2);
    chk("def_spd_end", bus.speed_used, 2'b10);
    cyc_g(1'b0, 1'b0, 4'h9, 4'h0);
    chk("def_spd_10", bus.speed_used, 2'b00);
    repeat (2) cyc(1'b0, 1'b0, 4'h9, 4'h0);
    chk("def_drain", sbq.size(), 0);
    // 10M frame with one errored nibble
    push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    push(8'h21, 1'b0);
    push(8'h43, 1'b1);
    push(8'h65, 1'b0);
    nibs('{4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2});
    cyc(1'b1, 1'b0, 4'h3, 4'h0);
    nibs('{4'h4, 4'h5, 4'h6});
    repeat (2) cyc(1'b0, 1'b0, 4'h9, 4'h0);
    chk("m10_drain", sbq.size(), 0);
    chk("m10_cnt", bus.align_err_cnt, 1);
    // reset in the middle of a 10M frame, holding a low nibble
    push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    nibs('{4'h5, 4'h5, 4'h5, 4'hD, 4'h7});
    rst = 1'b1;
    sb_on = 1'b0;
    #1;
    chk("mrst_en", bus.gmii_rx_en, 0);
    chk("mrst_rxd", bus.gmii_rxd, 0);
    chk("mrst_dv", bus.gmii_rx_dv, 0);
    chk("mrst_er", bus.gmii_rx_er, 0);
    chk("mrst_link", bus.link_up, 0);
    chk("mrst_spd", bus.speed_used, 2'b10);
    chk("mrst_cnt", bus.align_err_cnt, 0);
    chk("mrst_drain", sbq.size(), 0);
    repeat (2) cyc(1'b0, 1'b0, 4'h9, 4'h0);
    rst = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 4'h9, 4'h0);
    chk("post_spd", bus.speed_used, 2'b00);
    cyc(1'b0, 1'b0, 4'h9, 4'h0);
    sb_on = 1'b1;
    push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    push(8'h98, 1'b0);
    nibs('{4'h5, 4'h5, 4'hD, 4'h8, 4'h9});
    repeat (2) cyc(1'b0, 1'b0, 4'h9, 4'h0);
    chk("post_drain", sbq.size(), 0);
    chk("post_cnt", bus.align_err_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
